// File: rtl/proc_mem.sv
// proc_mem: unified instruction/data memory for a small processor, with a
// loader port that fills the memory before the processor is released.
//
// Two phases:
//   LOAD - the loader writes words; processor ports are ignored and the
//          processor is held in reset (proc_go = 0).
//   RUN  - entered on ld_done; the processor fetches (registered, 1-cycle
//          latency) and loads/stores (combinational read, write at edge).
//
// Any valid-qualified access to a misaligned or out-of-range byte address
// is dropped (no write, read data 0) and sets a sticky err flag; err_addr
// keeps the address of the first such access.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imemreq_val/addr         fetch request
//   imemresp_data            fetched word, registered
//   dmemreq_val/type/addr/wdata  data request (type 0 = load, 1 = store)
//   dmemresp_data            load data, combinational
//   ld_val/ld_addr/ld_data   loader write port, ld_rdy = accepted
//   ld_done                  loader finished, move to RUN
//   proc_go                  processor release
//   err, err_addr            sticky access error and first error address
module proc_mem #(
    parameter int NWORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imemreq_val,
    input  logic [31:0] imemreq_addr,
    output logic [31:0] imemresp_data,
    input  logic        dmemreq_val,
    input  logic        dmemreq_type,
    input  logic [31:0] dmemreq_addr,
    input  logic [31:0] dmemreq_wdata,
    output logic [31:0] dmemresp_data,
    input  logic        ld_val,
    output logic        ld_rdy,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    input  logic        ld_done,
    output logic        proc_go,
    output logic        err,
    output logic [31:0] err_addr
);

    localparam int AW = $clog2(NWORDS);

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;

    // Word aligned and inside the array: upper bits above the array must be 0.
    function automatic logic addr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a[31:AW+2] == '0);
    endfunction

    logic [31:0] mem [NWORDS];

    logic [AW-1:0] i_idx, d_idx, l_idx;
    logic          i_ok, d_ok, l_ok;
    logic          running;
    logic          i_err, d_err, l_err;

    assign i_idx   = imemreq_addr[AW+1:2];
    assign d_idx   = dmemreq_addr[AW+1:2];
    assign l_idx   = ld_addr[AW+1:2];
    assign i_ok    = addr_ok(imemreq_addr);
    assign d_ok    = addr_ok(dmemreq_addr);
    assign l_ok    = addr_ok(ld_addr);
    assign running = (state == RUN);

    assign i_err = running  && imemreq_val && !i_ok;
    assign d_err = running  && dmemreq_val && !d_ok;
    assign l_err = !running && ld_val      && !l_ok;

    // Single write port shared by the loader (LOAD) and stores (RUN).
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block leaves it unassigned and a latch is never inferred.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = l_idx;
        mem_wdata = ld_data;
        if (!rst) begin
            if (!running) begin
                mem_we = ld_val && l_ok;
            end else if (dmemreq_val && dmemreq_type && d_ok) begin
                mem_we    = 1'b1;
                mem_waddr = d_idx;
                mem_wdata = dmemreq_wdata;
            end
        end
    end

    // NOTE: the storage array has no reset on purpose; its contents must
    // survive rst, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        dmemresp_data = '0;
        if (running && dmemreq_val && !dmemreq_type && d_ok) begin
            dmemresp_data = mem[d_idx];
        end
    end

    // Control FSM with registered outputs. The fetch register reads the array
    // before this edge's store lands, so a same-cycle fetch sees the old word.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= LOAD;
            proc_go       <= 1'b0;
            ld_rdy        <= 1'b1;
            imemresp_data <= '0;
            err           <= 1'b0;
            err_addr      <= '0;
        end else if (state == LOAD) begin
            imemresp_data <= '0;
            if (l_err) begin
                err <= 1'b1;
                if (!err) begin
                    err_addr <= ld_addr;
                end
            end
            if (ld_done) begin
                state   <= RUN;
                proc_go <= 1'b1;
                ld_rdy  <= 1'b0;
            end
        end else begin
            if (imemreq_val) begin
                imemresp_data <= i_ok ? mem[i_idx] : '0;
            end
            if (i_err || d_err) begin
                err <= 1'b1;
                // Data-port address takes priority when both ports error.
                if (!err) begin
                    err_addr <= d_err ? dmemreq_addr : imemreq_addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_proc_mem.sv
// Self-checking bench for proc_mem: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against
// a behavioural model of the memory and its LOAD/RUN/err rules.
module tb_proc_mem;

    localparam int NW = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imemreq_val = 1'b0;
    logic [31:0] imemreq_addr = '0;
    logic [31:0] imemresp_data;
    logic        dmemreq_val = 1'b0;
    logic        dmemreq_type = 1'b0;
    logic [31:0] dmemreq_addr = '0;
    logic [31:0] dmemreq_wdata = '0;
    logic [31:0] dmemresp_data;
    logic        ld_val = 1'b0;
    logic        ld_rdy;
    logic [31:0] ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic        ld_done = 1'b0;
    logic        proc_go;
    logic        err;
    logic [31:0] err_addr;

    int n_checks = 0;
    int n_errors = 0;

    proc_mem #(.NWORDS(NW)) dut (
        .clk           (clk),
        .rst           (rst),
        .imemreq_val   (imemreq_val),
        .imemreq_addr  (imemreq_addr),
        .imemresp_data (imemresp_data),
        .dmemreq_val   (dmemreq_val),
        .dmemreq_type  (dmemreq_type),
        .dmemreq_addr  (dmemreq_addr),
        .dmemreq_wdata (dmemreq_wdata),
        .dmemresp_data (dmemresp_data),
        .ld_val        (ld_val),
        .ld_rdy        (ld_rdy),
        .ld_addr       (ld_addr),
        .ld_data       (ld_data),
        .ld_done       (ld_done),
        .proc_go       (proc_go),
        .err           (err),
        .err_addr      (err_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [NW];
    bit          m_known = 0;
    bit          m_run   = 0;
    logic [31:0] m_imem  = '0;
    bit          m_err   = 0;
    logic [31:0] m_erra  = '0;

    function automatic bit addr_valid(input logic [31:0] a);
        return (a % 4 == 0) && (a < 4 * NW);
    endfunction

    function automatic logic [31:0] exp_dresp();
        if (m_run && dmemreq_val && !dmemreq_type && addr_valid(dmemreq_addr))
            return m_mem[dmemreq_addr / 4];
        return 32'h0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_known = 1;
            m_run   = 0;
            m_imem  = 0;
            m_err   = 0;
            m_erra  = 0;
        end else if (!m_run) begin
            m_imem = 0;
            if (ld_val) begin
                if (addr_valid(ld_addr)) m_mem[ld_addr / 4] = ld_data;
                else begin
                    if (!m_err) m_erra = ld_addr;
                    m_err = 1;
                end
            end
            if (ld_done) m_run = 1;
        end else begin
            bit fe, de;
            fe = imemreq_val && !addr_valid(imemreq_addr);
            de = dmemreq_val && !addr_valid(dmemreq_addr);
            // fetch observes memory as it was before this cycle's store
            if (imemreq_val) m_imem = fe ? 32'h0 : m_mem[imemreq_addr / 4];
            if (dmemreq_val && dmemreq_type && !de) m_mem[dmemreq_addr / 4] = dmemreq_wdata;
            if (fe || de) begin
                if (!m_err) m_erra = de ? dmemreq_addr : imemreq_addr;
                m_err = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            check("proc_go", {31'b0, proc_go}, {31'b0, m_run});
            check("ld_rdy", {31'b0, ld_rdy}, {31'b0, !m_run});
            check("imemresp_data", imemresp_data, m_imem);
            check("dmemresp_data", dmemresp_data, exp_dresp());
            check("err", {31'b0, err}, {31'b0, m_err});
            check("err_addr", err_addr, m_erra);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return {22'b0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
        if (r == 1) return 32'h400 + 32'($urandom_range(0, 4095)) * 4;
        return {22'b0, 8'($urandom_range(0, 255)), 2'b00};
    endfunction

    initial begin
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_ld_rdy", {31'b0, ld_rdy}, 32'h1);
        check("rst_proc_go", {31'b0, proc_go}, 32'h0);
        check("rst_imem", imemresp_data, 32'h0);
        check("rst_err", {31'b0, err}, 32'h0);

        // Fill the whole array so every later read is defined.
        for (int i = 0; i < NW; i++) begin
            ld_val  = 1'b1;
            ld_addr = 32'(i * 4);
            ld_data = $urandom;
            // processor ports must be ignored while loading
            dmemreq_val   = 1'b1;
            dmemreq_type  = 1'b1;
            dmemreq_addr  = 32'h100;
            dmemreq_wdata = 32'hFFFF_FFFF;
            step();
        end
        dmemreq_val = 1'b0;
        ld_addr = 32'h0; ld_data = 32'h0000_0013;
        step();
        ld_addr = 32'h4; ld_data = 32'h0050_0093; ld_done = 1'b1;
        step();
        ld_val = 1'b0; ld_done = 1'b0;
        check("go_after_done", {31'b0, proc_go}, 32'h1);
        check("rdy_after_done", {31'b0, ld_rdy}, 32'h0);

        imemreq_val = 1'b1; imemreq_addr = 32'h4;
        step();
        check("fetch_0x4", imemresp_data, 32'h0050_0093);
        imemreq_val = 1'b0; imemreq_addr = 32'h0;
        step();
        check("fetch_hold", imemresp_data, 32'h0050_0093);

        dmemreq_val = 1'b1; dmemreq_type = 1'b1; dmemreq_addr = 32'h100; dmemreq_wdata = 32'hDEAD_BEEF;
        step();
        dmemreq_type = 1'b0;
        #1;
        check("load_0x100", dmemresp_data, 32'hDEAD_BEEF);
        step();

        imemreq_val = 1'b1; imemreq_addr = 32'h100;
        dmemreq_type = 1'b1; dmemreq_wdata = 32'h1234_5678;
        step();
        check("fetch_old_word", imemresp_data, 32'hDEAD_BEEF);
        dmemreq_val = 1'b0;
        step();
        check("fetch_new_word", imemresp_data, 32'h1234_5678);
        imemreq_val = 1'b0;

        dmemreq_val = 1'b1; dmemreq_type = 1'b0; dmemreq_addr = 32'h102;
        #1;
        check("misaligned_load", dmemresp_data, 32'h0);
        step();
        check("err_set", {31'b0, err}, 32'h1);
        check("err_addr_first", err_addr, 32'h102);
        dmemreq_type = 1'b1; dmemreq_addr = 32'h400; dmemreq_wdata = 32'h0BAD_0BAD;
        step();
        check("err_addr_kept", err_addr, 32'h102);
        dmemreq_type = 1'b0; dmemreq_addr = 32'h0;
        #1;
        check("word0_unchanged", dmemresp_data, 32'h0000_0013);
        step();
        dmemreq_val = 1'b0;

        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rerst_go", {31'b0, proc_go}, 32'h0);
        check("rerst_err", {31'b0, err}, 32'h0);
        check("rerst_rdy", {31'b0, ld_rdy}, 32'h1);
        ld_done = 1'b1;
        step();
        ld_done = 1'b0;
        check("rerun_go", {31'b0, proc_go}, 32'h1);
        imemreq_val = 1'b1; imemreq_addr = 32'h100;
        step();
        check("survives_rst", imemresp_data, 32'h1234_5678);

        // Randomized traffic, including resets, reloads and bad addresses.
        for (int c = 0; c < 4000; c++) begin
            rst           = ($urandom_range(0, 399) == 0);
            imemreq_val   = 1'($urandom_range(0, 1));
            imemreq_addr  = rand_addr();
            dmemreq_val   = 1'($urandom_range(0, 1));
            dmemreq_type  = 1'($urandom_range(0, 1));
            dmemreq_addr  = rand_addr();
            dmemreq_wdata = $urandom;
            ld_val        = 1'($urandom_range(0, 1));
            ld_addr       = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
            ld_data       = $urandom;
            ld_done       = ($urandom_range(0, 15) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
